// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Boot loader; assembles a LE byte stream into instruction words,
//            writes them to instruction memory, then releases the core reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0]  c_CNT_LO  = 3'd0;
    localparam logic [2:0]  c_CNT_HI  = 3'd1;
    localparam logic [2:0]  c_DATA    = 3'd2;
    localparam logic [2:0]  c_CSUM    = 3'd3;
    localparam logic [2:0]  c_DONE    = 3'd4;
    localparam logic [2:0]  c_ERROR   = 3'd5;
    localparam logic [15:0] c_DEPTH16 = 16'(DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              w_active;
    logic              w_accept;
    logic [15:0]       r_count;
    logic [15:0]       w_count_full;
    logic [23:0]       r_word;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W:0]   r_words;
    logic [7:0]        r_xor;
    logic              w_last_byte;
    logic              w_last_word;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_rst_n;

    assign w_accept     = rx_valid && rx_ready;
    assign w_count_full = {rx_data, r_count[7:0]};
    assign w_last_byte  = (r_byte_idx == 2'd3);
    assign w_last_word  = ((16'(r_words) + 16'd1) == r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_CNT_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_accept) begin
            case (r_state)
                c_CNT_LO: w_next = c_CNT_HI;
                c_CNT_HI: begin
                    if (w_count_full == 16'd0 || w_count_full > c_DEPTH16) begin
                        w_next = c_ERROR;
                    end else begin
                        w_next = c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_last_byte && w_last_word) begin
                        w_next = c_CSUM;
                    end
                end
                c_CSUM:  w_next = (rx_data == r_xor) ? c_DONE : c_ERROR;
                default: w_next = r_state;
            endcase
        end
    end

    // Handshake-facing outputs are held low while rst is asserted.
    always_comb begin
        w_active = 1'b0;
        case (r_state)
            c_CNT_LO, c_CNT_HI, c_DATA, c_CSUM: w_active = 1'b1;
            default:                            w_active = 1'b0;
        endcase
        rx_ready = w_active && !rst;
        busy     = w_active && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_done      <= (w_next == c_DONE);
            r_error     <= (w_next == c_ERROR);
            r_cpu_rst_n <= (w_next == c_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 16'd0;
            r_word     <= 24'd0;
            r_byte_idx <= 2'd0;
            r_words    <= '0;
            r_xor      <= 8'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    c_CNT_LO: r_count[7:0]  <= rx_data;
                    c_CNT_HI: r_count[15:8] <= rx_data;
                    c_DATA: begin
                        r_xor      <= r_xor ^ rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= rx_data;
                            2'd1: r_word[15:8]  <= rx_data;
                            2'd2: r_word[23:16] <= rx_data;
                            default: begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_words[ADDR_W-1:0];
                                r_wr_data <= WIDTH'({rx_data, r_word});
                                r_words   <= r_words + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign done         = r_done;
    assign error        = r_error;
    assign cpu_rst_n    = r_cpu_rst_n;
    assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench for imem_loader with a stream-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    logic [31:0] wq[$];
    int          errors = 0;
    int          checks = 0;
    bit          exp_done;
    int          exp_words;
    int          cyc = 0;
    int          last_wr = -100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_wr = -100;
        end else if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {26'd0, wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.a));
                chk("wr_data", 64'(wr_data), 64'(e.d));
            end
            if (last_wr >= 0) chk("wr_spacing_ge4", 64'(cyc - last_wr >= 4), 64'd1);
            last_wr = cyc;
        end
    end

    // Reference model: builds the byte stream and expected writes/outcome from wq.
    task automatic make_stream(input int n, input bit fill_random, input logic [7:0] corrupt);
        logic [7:0] x;
        bit         ok;
        stream.delete();
        if (fill_random) begin
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
        end
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        ok = (n >= 1) && (n <= DEPTH);
        x = 8'd0;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                wr_t e;
                for (int b = 0; b < 4; b++) begin
                    stream.push_back(wq[i][8*b +: 8]);
                    x = x ^ wq[i][8*b +: 8];
                end
                e.a = ADDR_W'(i);
                e.d = wq[i];
                exp_q.push_back(e);
            end
            stream.push_back(x ^ corrupt);
        end
        exp_done  = ok && (corrupt == 8'd0);
        exp_words = ok ? n : 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last accepted byte.
    task automatic send(input int gap_max);
        foreach (stream[i]) begin
            rx_valid = 1'b0;
            repeat ((gap_max > 0) ? $urandom_range(0, gap_max) : 0) begin
                @(posedge clk); #1;
            end
            rx_data  = stream[i];
            rx_valid = 1'b1;
            if (!rx_ready) begin
                rx_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_final(input string tag);
        @(negedge clk); #1;
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(!exp_done));
        chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
        chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Good load, continuous then gapped.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            wq.delete();
            wq.push_back(32'h2008_0005);
            wq.push_back(32'h2009_000C);
            wq.push_back(32'hAC09_0004);
            make_stream(3, 1'b0, 8'd0);
            send(pass == 0 ? 0 : 5);
            check_final(pass == 0 ? "good" : "good_gaps");
        end

        // Bad checksum: 0x08 expected, 0x00 sent; further bytes ignored.
        do_reset();
        wq.delete();
        wq.push_back(32'h1234_5678);
        make_stream(1, 1'b0, 8'h08);
        chk("bad_csum_byte", 64'(stream[6]), 64'd0);
        send(0);
        check_final("bad_csum");
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("ignored_error", 64'(error), 64'd1);
        chk("ignored_words", 64'(words_loaded), 64'd1);
        chk("ignored_rx_ready", 64'(rx_ready), 64'd0);

        // Illegal counts.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            make_stream(k == 0 ? 0 : DEPTH + 1, 1'b1, 8'd0);
            send(2);
            check_final(k == 0 ? "cnt0" : "cnt65");
        end

        // Full-depth load.
        do_reset();
        make_stream(DEPTH, 1'b1, 8'd0);
        send(1);
        check_final("full_depth");

        // Randomized loads, some with a corrupted checksum.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            make_stream($urandom_range(1, 8), 1'b1,
                        ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
            send(3);
            check_final("random");
        end

        // Reset after 6 data bytes of a 2-word load; a byte is offered on the reset edge.
        do_reset();
        make_stream(2, 1'b1, 8'd0);
        while (stream.size() > 8) void'(stream.pop_back());
        send(0);
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midload");
        chk("midload_word1_unwritten", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        make_stream(1, 1'b1, 8'd0);
        send(0);
        check_final("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the instruction memory feeding the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them into consecutive instruction-memory addresses and verifies an XOR checksum. Only after a successful load does it release the core's active-low reset.

## Interface
- WIDTH, 32, instruction word width (fixed at 32; 4 bytes per word)
- DEPTH, 64, instruction memory depth in words
- ADDR_W, 6, word-address width, equal to clog2(DEPTH)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; one clock `clk`, and `rst` is synchronous and active-high
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader can accept a byte; a byte transfers on an edge where rx_valid && rx_ready
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  WIDTH  instruction word for the write
- cpu_rst_n  output  1  active-low reset to the MIPS core; 1 only in DONE
- busy  output  1  load in progress (states CNT_LO..CSUM)
- done  output  1  load completed with a good checksum (sticky)
- error  output  1  load rejected (sticky)
- words_loaded  output  ADDR_W+1  number of words written so far

## Operation
- Stream format: count low byte, count high byte (N, 16-bit), then N×4 data bytes (word k's byte 0 is its LSB), then 1 checksum byte.
- The checksum is the XOR of all data bytes only. The count bytes are not included.
- States:
  - CNT_LO: capture N[7:0]; next CNT_HI.
  - CNT_HI: capture N[15:8]. If the full N is 0 or N > DEPTH, go to ERROR; otherwise go to DATA.
  - DATA: shift bytes into the word assembler and fold each byte into the running XOR. On the 4th byte of a word, issue a write and increment the word index. After the 4th byte of word N-1, go to CSUM.
  - CSUM: compare the received byte with the running XOR. On a match go to DONE; on a mismatch go to ERROR.
  - DONE, ERROR: terminal. Both hold until rst.
- The state advances only on an accepted byte. rx_valid low stalls indefinitely with no timeout.
- rx_ready = 1 in CNT_LO, CNT_HI, DATA and CSUM; 0 in DONE and ERROR. In DONE and ERROR, bytes are not consumed.
- Word writes go to wr_addr = 0, 1, …, N-1 in order. No address wrap is possible because N ≤ DEPTH is enforced.
- words_loaded counts writes issued and saturates at N. It is not cleared on ERROR, which aids debug.
- The core stays in reset on ERROR. Recovery requires rst.

## Timing
- Reset values:
  - state CNT_LO
  - rx_ready 1 from the first cycle after rst deasserts (0 while rst is high)
  - wr_en 0, wr_addr 0, wr_data 0
  - cpu_rst_n 0, busy 0 (1 from the first cycle after rst deasserts), done 0, error 0
  - words_loaded 0, running XOR 0, count 0
- wr_en, wr_addr and wr_data are registered. They are valid for exactly 1 cycle, the cycle after the edge that accepted the word's 4th byte. The memory captures on the following edge.
- Back-to-back bytes at 1 byte/cycle are sustained. The minimum spacing between wr_en pulses is 4 cycles.
- The last word's write completes no later than the edge that accepts the checksum byte.
- done, error, busy and cpu_rst_n are registered from the state. They change in the cycle after the deciding byte is accepted:
  - good checksum: done=1, cpu_rst_n=1, busy=0, all in the same cycle.
  - bad checksum, or bad count on the CNT_HI byte: error=1, busy=0, cpu_rst_n remains 0.
- done and error are never both 1.
- rst asserted mid-load aborts on that edge and returns every output and all state to its reset value. A partially assembled word is discarded and never written. Words already written remain in memory but are not counted.
- rst has priority over a byte transfer occurring on the same edge.

## Test plan
- Good load, continuous valid: 03 00, then words 0x20080005, 0x2009000C, 0xAC090004 as LE bytes, then their XOR checksum.
  - Required: 3 wr_en pulses at addr 0, 1, 2 with exact data, each 1 cycle long and ≥4 cycles apart.
  - Then done=1, cpu_rst_n=1, words_loaded=3, rx_ready=0.
- Same stream with rx_valid randomly deasserted 0-5 cycles between bytes. Required: identical writes and final state; no byte lost or duplicated.
- Bad checksum: 01 00, 78 56 34 12, checksum 0x00 (the correct value is 0x08).
  - Required: one write of 0x12345678 to addr 0, then error=1, done=0, cpu_rst_n=0, rx_ready=0.
  - Further bytes are ignored.
- Count 0 (00 00) and count DEPTH+1 (41 00). Required: error=1 the cycle after the second byte, no wr_en ever, words_loaded=0.
- Count DEPTH (40 00) with 256 data bytes and the correct checksum. Required: 64 writes at addr 0..63, done=1, words_loaded=64.
- rst for 1 cycle after 6 data bytes of a 2-word load, then a full good 1-word load.
  - Required: all outputs return to reset values on the reset edge; word 1's partial bytes are never written.
  - The subsequent load writes addr 0 and reaches done=1.
